kmc_npr_ctrl: RTL and testbench

- NPR (DMA) responder for the KMC11 microprocessor.
- Microcode posts an NPR request (address, direction, byte/word, write data) through the NPR control and output-bus registers. This block runs the single bus transaction on the KS10 unibus-adapter DMA port and returns read data and status to the microprocessor input bus.
- It is the far end of the microcode's NPR handshake: it clears the NPR RQ bit when done and flags non-existent memory on timeout.

---
 rtl/kmc_npr_ctrl_if.sv | 42 ++++
 rtl/kmc_npr_ctrl.sv | 117 +++++++++++
 tb/tb_kmc_npr_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kmc_npr_ctrl_if.sv
// KMC11 NPR interface.
// Bundles the microcode-side NPR request/status signals and the
// unibus-adapter DMA port into one interface.
// The slave modport is the NPR controller. The master modport is the side that
// drives the microcode requests and the adapter responses.
interface kmc_npr_ctrl_if #(
    parameter int AWIDTH = 18
);
    // Microcode side of the NPR handshake
    logic              npr_start;
    logic              npr_out;
    logic              npr_byte;
    logic [AWIDTH-1:0] npr_addr;
    logic [15:0]       npr_wdata;
    logic              npr_busy;
    logic              npr_done;
    logic              npr_nxm;
    logic [15:0]       npr_rdata;

    // Adapter DMA port
    logic              dma_req;
    logic              dma_write;
    logic              dma_byte;
    logic [AWIDTH-1:0] dma_addr;
    logic [15:0]       dma_wdata;
    logic              dma_ack;
    logic [15:0]       dma_rdata;

    modport slave (
        input  npr_start, npr_out, npr_byte, npr_addr, npr_wdata,
        output npr_busy, npr_done, npr_nxm, npr_rdata,
        output dma_req, dma_write, dma_byte, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata
    );

    modport master (
        output npr_start, npr_out, npr_byte, npr_addr, npr_wdata,
        input  npr_busy, npr_done, npr_nxm, npr_rdata,
        input  dma_req, dma_write, dma_byte, dma_addr, dma_wdata,
        output dma_ack, dma_rdata
    );
endinterface

// File: rtl/kmc_npr_ctrl.sv
// KMC11 NPR (DMA) responder.
// Takes one NPR request posted by microcode and runs it as a single
// transaction on the KS10 adapter DMA port. It then returns read data and
// status, and flags non-existent memory if the adapter never acknowledges.
module kmc_npr_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int AWIDTH  = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_kmc_init,
    kmc_npr_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);

    state_t            r_state;
    logic [15:0]       r_count;
    logic              r_busy;
    logic              r_done;
    logic              r_nxm;
    logic [15:0]       r_rdata;
    logic              r_req;
    logic              r_write;
    logic              r_byte;
    logic [AWIDTH-1:0] r_addr;
    logic [15:0]       r_wdata;

    // Word cycles always present an even address. The full latched address is
    // still kept, because byte reads need bit 0 for lane selection.
    logic [AWIDTH-1:0] w_dmaAddr;
    assign w_dmaAddr = {r_addr[AWIDTH-1:1], r_addr[0] & r_byte};

    // Request FSM.
    // IDLE accepts a request, REQ holds the bus request until ack or timeout,
    // and DONE issues the completion pulse and drops busy.
    always_ff @(posedge clk) begin
        if (rst || i_kmc_init) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nxm   <= 1'b0;
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.npr_start) begin
                        r_addr  <= bus.npr_addr;
                        r_write <= bus.npr_out;
                        r_byte  <= bus.npr_byte;
                        r_wdata <= bus.npr_byte ? {bus.npr_wdata[7:0], bus.npr_wdata[7:0]}
                                                : bus.npr_wdata;
                        r_nxm   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_count <= TIMEOUT_LOAD;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.dma_ack) begin
                        r_req  <= 1'b0;
                        r_done <= 1'b1;
                        if (!r_write) begin
                            if (r_byte) begin
                                r_rdata <= {8'h00, r_addr[0] ? bus.dma_rdata[15:8]
                                                             : bus.dma_rdata[7:0]};
                            end else begin
                                r_rdata <= bus.dma_rdata;
                            end
                        end
                        r_state <= S_DONE;
                    end else if (r_count == 16'd0) begin
                        r_nxm   <= 1'b1;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - 16'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.npr_busy  = r_busy;
    assign bus.npr_done  = r_done;
    assign bus.npr_nxm   = r_nxm;
    assign bus.npr_rdata = r_rdata;
    assign bus.dma_req   = r_req;
    assign bus.dma_write = r_write;
    assign bus.dma_byte  = r_byte;
    assign bus.dma_addr  = w_dmaAddr;
    assign bus.dma_wdata = r_wdata;

endmodule

// File: tb/tb_kmc_npr_ctrl.sv
// Self-checking bench for the KMC11 NPR responder.
// Uses directed scenarios plus randomized transfers. Expected values come
// from a transaction-level model of the NPR rules.
module tb_kmc_npr_ctrl;

    localparam int TIMEOUT = 4;
    localparam int AWIDTH  = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kmcInit = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Model state that persists across transfers
    logic [15:0] expRdata = 16'h0000;

    kmc_npr_ctrl_if #(.AWIDTH(AWIDTH)) bus ();

    kmc_npr_ctrl #(.TIMEOUT(TIMEOUT), .AWIDTH(AWIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_kmc_init (kmcInit),
        .bus        (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Runs one NPR transfer. The ack arrives in REQ cycle ackDelay (0-based);
    // values above TIMEOUT mean no ack at all. Optionally pokes a stray start
    // while busy and/or during DONE, neither of which may be accepted.
    task automatic doTransfer(input bit out, input bit byteMode,
                              input logic [17:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdIn, input int ackDelay,
                              input bit ignoreStart, input bit startInDone,
                              input string tag);
        int expReq;
        bit expNxm;
        logic [17:0] expAddr;
        logic [15:0] expWdata;
        int doneCyc;

        expNxm   = (ackDelay > TIMEOUT);
        expReq   = expNxm ? TIMEOUT + 1 : ackDelay + 1;
        expAddr  = byteMode ? addr : addr - 18'(addr % 2);
        expWdata = byteMode ? 16'((wdata % 256) * 257) : wdata;

        @(negedge clk);
        bus.npr_start = 1'b1;
        bus.npr_out   = out;
        bus.npr_byte  = byteMode;
        bus.npr_addr  = addr;
        bus.npr_wdata = wdata;
        @(negedge clk);
        bus.npr_start = 1'b0;

        doneCyc = -1;
        for (int cyc = 0; cyc < TIMEOUT + 20; cyc++) begin
            if (bus.npr_done === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            if (cyc < expReq) begin
                vectors++;
                if (bus.dma_req !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s dma_req cyc %0d got %b want 1", tag, cyc, bus.dma_req);
                end
                vectors++;
                if (bus.dma_addr !== expAddr || bus.dma_write !== out || bus.dma_byte !== byteMode) begin
                    miscompares++;
                    $display("FAIL %s dma_fields cyc %0d got addr %o w %b b %b want addr %o w %b b %b",
                             tag, cyc, bus.dma_addr, bus.dma_write, bus.dma_byte, expAddr, out, byteMode);
                end
                vectors++;
                if (out && bus.dma_wdata !== expWdata) begin
                    miscompares++;
                    $display("FAIL %s dma_wdata got %h want %h", tag, bus.dma_wdata, expWdata);
                end
                vectors++;
                if (bus.npr_busy !== 1'b1 || bus.npr_nxm !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy/nxm in REQ got %b/%b want 1/0", tag, bus.npr_busy, bus.npr_nxm);
                end
            end
            if (ignoreStart && cyc == 0) begin
                bus.npr_start = 1'b1;
                bus.npr_addr  = 18'o777776;
                bus.npr_out   = ~out;
            end else begin
                bus.npr_start = 1'b0;
            end
            bus.dma_ack   = (cyc == ackDelay);
            bus.dma_rdata = (cyc == ackDelay) ? rdIn : 16'($urandom);
            @(negedge clk);
        end
        bus.dma_ack   = 1'b0;
        bus.npr_start = 1'b0;

        if (!expNxm && !out) begin
            expRdata = byteMode ? ((addr % 2 == 1) ? rdIn / 256 : rdIn % 256) : rdIn;
        end

        vectors++;
        if (doneCyc != expReq) begin
            miscompares++;
            $display("FAIL %s done_latency got %0d want %0d", tag, doneCyc, expReq);
        end
        vectors++;
        if (bus.dma_req !== 1'b0 || bus.npr_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req/busy in DONE got %b/%b want 0/1", tag, bus.dma_req, bus.npr_busy);
        end
        vectors++;
        if (bus.npr_nxm !== expNxm) begin
            miscompares++;
            $display("FAIL %s npr_nxm got %b want %b", tag, bus.npr_nxm, expNxm);
        end
        vectors++;
        if (bus.npr_rdata !== expRdata) begin
            miscompares++;
            $display("FAIL %s npr_rdata got %h want %h", tag, bus.npr_rdata, expRdata);
        end

        if (startInDone) begin
            bus.npr_start = 1'b1;
            bus.npr_addr  = 18'o777776;
        end
        @(negedge clk);
        bus.npr_start = 1'b0;
        vectors++;
        if (bus.npr_done !== 1'b0 || bus.npr_busy !== 1'b0 || bus.dma_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done got done %b busy %b req %b want 0 0 0",
                     tag, bus.npr_done, bus.npr_busy, bus.dma_req);
        end
        @(negedge clk);
        vectors++;
        if (bus.dma_req !== 1'b0 || bus.npr_busy !== 1'b0 || bus.npr_nxm !== expNxm) begin
            miscompares++;
            $display("FAIL %s idle_hold got req %b busy %b nxm %b want 0 0 %b",
                     tag, bus.dma_req, bus.npr_busy, bus.npr_nxm, expNxm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.npr_busy, bus.npr_done, bus.npr_nxm, bus.dma_req, bus.dma_write, bus.dma_byte} !== 6'b0
            || bus.npr_rdata !== 16'h0 || bus.dma_addr !== 18'h0 || bus.dma_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy %b done %b nxm %b req %b rdata %h addr %o want all 0",
                     bus.npr_busy, bus.npr_done, bus.npr_nxm, bus.dma_req, bus.npr_rdata, bus.dma_addr);
        end
        rst = 1'b0;
        expRdata = 16'h0000;
    endtask

    task automatic test_word_read();
        doTransfer(1'b0, 1'b0, 18'o001000, 16'h0000, 16'h1234, 2, 1'b0, 1'b0, "word_read");
    endtask

    task automatic test_byte_write();
        doTransfer(1'b1, 1'b1, 18'o001001, 16'h3CA5, 16'hFFFF, 1, 1'b0, 1'b0, "byte_write");
    endtask

    task automatic test_byte_reads();
        doTransfer(1'b0, 1'b1, 18'o002001, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0, "byte_read_odd");
        doTransfer(1'b0, 1'b1, 18'o002000, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0, "byte_read_even");
    endtask

    task automatic test_nxm();
        doTransfer(1'b0, 1'b0, 18'o003000, 16'h0000, 16'h5555, 99, 1'b0, 1'b0, "nxm_timeout");
        doTransfer(1'b1, 1'b0, 18'o003002, 16'h7777, 16'h0000, TIMEOUT, 1'b0, 1'b0, "ack_last_cycle");
    endtask

    task automatic test_ignored_start();
        doTransfer(1'b0, 1'b0, 18'o004000, 16'h0000, 16'hCAFE, 3, 1'b1, 1'b1, "ignored_start");
    endtask

    task automatic test_kmc_init();
        @(negedge clk);
        bus.npr_start = 1'b1;
        bus.npr_out   = 1'b0;
        bus.npr_byte  = 1'b0;
        bus.npr_addr  = 18'o005000;
        @(negedge clk);
        bus.npr_start = 1'b0;
        @(negedge clk);
        kmcInit = 1'b1;
        @(negedge clk);
        kmcInit = 1'b0;
        expRdata = 16'h0000;
        vectors++;
        if (bus.dma_req !== 1'b0 || bus.npr_busy !== 1'b0 || bus.npr_done !== 1'b0
            || bus.npr_rdata !== expRdata || bus.npr_nxm !== 1'b0) begin
            miscompares++;
            $display("FAIL kmc_init_abort got req %b busy %b done %b rdata %h nxm %b want 0 0 0 0000 0",
                     bus.dma_req, bus.npr_busy, bus.npr_done, bus.npr_rdata, bus.npr_nxm);
        end
        bus.dma_ack   = 1'b1;
        bus.dma_rdata = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.dma_ack = 1'b0;
            vectors++;
            if (bus.npr_done !== 1'b0 || bus.npr_busy !== 1'b0 || bus.npr_rdata !== expRdata) begin
                miscompares++;
                $display("FAIL kmc_init_late_ack cyc %0d got done %b busy %b rdata %h want 0 0 %h",
                         i, bus.npr_done, bus.npr_busy, bus.npr_rdata, expRdata);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            doTransfer(1'($urandom), 1'($urandom), 18'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    // Scenario sequence
    initial begin
        bus.npr_start = 1'b0;
        bus.npr_out   = 1'b0;
        bus.npr_byte  = 1'b0;
        bus.npr_addr  = '0;
        bus.npr_wdata = '0;
        bus.dma_ack   = 1'b0;
        bus.dma_rdata = '0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_byte_reads();
        test_nxm();
        test_ignored_start();
        test_kmc_init();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
